// File: rtl/bitrev_unscramble_if.sv
// Purpose : lane-pair write bus plus natural-order read stream of bitrev_unscramble.
// Latency : none, signal bundle only.
// Backpr. : o_wr_ready throttles the writer; i_ready throttles the read stream.
// Ports   : slave = the unscrambler (consumes writes, produces reads);
//           master = its environment (source of pairs, sink of samples).
interface bitrev_unscramble_if #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 3
);
   logic                 i_wr_valid;
   logic                 o_wr_ready;
   logic [ADDR_SIZE-1:0] i_pipeaddr_A;
   logic [ADDR_SIZE-1:0] i_pipeaddr_B;
   logic [WORD_SIZE-1:0] i_pipedata_A;
   logic [WORD_SIZE-1:0] i_pipedata_B;
   logic                 o_valid;
   logic                 i_ready;
   logic [WORD_SIZE-1:0] o_data;
   logic [ADDR_SIZE-1:0] o_index;
   logic                 o_last;
   logic                 o_overflow;

   modport slave (
      input  i_wr_valid, i_pipeaddr_A, i_pipeaddr_B, i_pipedata_A, i_pipedata_B, i_ready,
      output o_wr_ready, o_valid, o_data, o_index, o_last, o_overflow
   );

   modport master (
      output i_wr_valid, i_pipeaddr_A, i_pipeaddr_B, i_pipedata_A, i_pipedata_B, i_ready,
      input  o_wr_ready, o_valid, o_data, o_index, o_last, o_overflow
   );
endinterface

// File: rtl/bitrev_unscramble.sv
// Purpose : reorders bit-reversed FFT sample pairs into natural-order frames via ping-pong banks.
// Latency : o_valid rises the cycle after the edge accepting a frame's last pair.
// Backpr. : o_wr_ready low while the write bank is still draining; pairs offered then are
//           dropped and flagged on sticky o_overflow. Output holds while o_valid && !i_ready.
// Ports   : i_CLK, i_RST (async, active high), bus (slave modport of bitrev_unscramble_if).
module bitrev_unscramble #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 3
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   bitrev_unscramble_if.slave     bus
);
   localparam int N  = 1 << ADDR_SIZE;
   // Pair counter needs ADDR_SIZE-1 bits; keep at least one bit so N=2 still elaborates.
   localparam int CW = (ADDR_SIZE > 1) ? ADDR_SIZE - 1 : 1;

   localparam logic [CW-1:0]        LAST_PAIR = CW'(N / 2 - 1);
   localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(N - 1);

   function automatic logic [ADDR_SIZE-1:0] f_rev(input logic [ADDR_SIZE-1:0] a);
      logic [ADDR_SIZE-1:0] r;
      for (int i = 0; i < ADDR_SIZE; i++) begin
         r[i] = a[ADDR_SIZE-1-i];
      end
      return r;
   endfunction

   // Frame storage, intentionally not reset.
   logic [WORD_SIZE-1:0] r_mem [2][N];

   logic          r_wr_bank;
   logic [CW-1:0] r_wr_cnt;
   logic          r_rd_bank;
   logic [ADDR_SIZE-1:0] r_rd_cnt;
   logic [1:0]    r_full;
   logic          r_overflow;

   logic                 w_wr_ready;
   logic                 w_wr_acc;
   logic                 w_frame_done;
   logic                 w_rd_vld;
   logic                 w_rd_xfer;
   logic                 w_drain_done;
   logic [ADDR_SIZE-1:0] w_idx_A;
   logic [ADDR_SIZE-1:0] w_idx_B;

   assign w_wr_ready   = !r_full[r_wr_bank];
   assign w_wr_acc     = bus.i_wr_valid && w_wr_ready;
   assign w_frame_done = w_wr_acc && (r_wr_cnt == LAST_PAIR);
   assign w_rd_vld     = r_full[r_rd_bank];
   assign w_rd_xfer    = w_rd_vld && bus.i_ready;
   assign w_drain_done = w_rd_xfer && (r_rd_cnt == LAST_IDX);
   assign w_idx_A      = f_rev(bus.i_pipeaddr_A);
   assign w_idx_B      = f_rev(bus.i_pipeaddr_B);

   // Lane B is written second so it wins when both lanes hit the same index.
   always_ff @(posedge i_CLK) begin
      if (w_wr_acc) begin
         r_mem[r_wr_bank][w_idx_A] <= bus.i_pipedata_A;
         r_mem[r_wr_bank][w_idx_B] <= bus.i_pipedata_B;
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
      end else if (w_wr_acc) begin
         if (w_frame_done) begin
            r_wr_bank <= !r_wr_bank;
            r_wr_cnt  <= '0;
         end else begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= '0;
      end else if (w_rd_xfer) begin
         if (w_drain_done) begin
            r_rd_bank <= !r_rd_bank;
            r_rd_cnt  <= '0;
         end else begin
            r_rd_cnt  <= r_rd_cnt + 1'b1;
         end
      end
   end

   // Set and clear always address different banks: a fill needs its bank empty,
   // a drain needs its bank full.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_full <= 2'b00;
      end else begin
         if (w_frame_done) begin
            r_full[r_wr_bank] <= 1'b1;
         end
         if (w_drain_done) begin
            r_full[r_rd_bank] <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_overflow <= 1'b0;
      end else if (bus.i_wr_valid && !w_wr_ready) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.o_wr_ready = w_wr_ready;
   assign bus.o_valid    = w_rd_vld;
   assign bus.o_index    = r_rd_cnt;
   assign bus.o_data     = w_rd_vld ? r_mem[r_rd_bank][r_rd_cnt] : '0;
   assign bus.o_last     = w_rd_vld && (r_rd_cnt == LAST_IDX);
   assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_bitrev_unscramble.sv
// Purpose : randomized bench for bitrev_unscramble against a frame-queue reference model.
// Latency : one check pass per clock, on the falling edge.
// Backpr. : randomized and scripted i_ready; source honours o_wr_ready except in overflow phase.
module tb_bitrev_unscramble;
   localparam int WS = 8;
   localparam int AS = 3;
   localparam int N  = 1 << AS;

   typedef struct {
      logic [AS-1:0] aa;
      logic [AS-1:0] ab;
      logic [WS-1:0] da;
      logic [WS-1:0] db;
   } pair_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bitrev_unscramble_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();

   bitrev_unscramble #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: natural-order samples of completed frames, in output order.
   int        exp_q[$];
   int        mb[2][N];
   int        mwb  = 0;
   int        mwcnt = 0;
   bit        movf = 0;
   pair_t     pend[$];
   int        rdy_force[$];
   int        cap_q[$];
   int        vprob = 100;
   int        rprob = 100;
   bit        ovf_mode = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int rev(input int a);
      int r = 0;
      for (int i = 0; i < AS; i++) begin
         r = r * 2 + ((a >> i) % 2);
      end
      return r;
   endfunction

   function automatic int m_full();
      return (exp_q.size() + N - 1) / N;
   endfunction

   function automatic int m_idx();
      return (N - (exp_q.size() % N)) % N;
   endfunction

   function automatic int rnd_data();
      int d;
      do d = $urandom_range(0, 255); while (d == 'hAA);
      return d;
   endfunction

   task automatic gen_frame(input bit collide);
      int perm[N];
      pair_t p;
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         int j = $urandom_range(0, i);
         int t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      if (collide) perm[1] = perm[0];
      for (int k = 0; k < N / 2; k++) begin
         p.aa = AS'(rev(perm[2*k]));
         p.ab = AS'(rev(perm[2*k+1]));
         p.da = WS'(rnd_data());
         p.db = WS'(rnd_data());
         pend.push_back(p);
      end
   endtask

   // One clock: check outputs against the model, drive the next inputs, advance the model.
   task automatic cycle();
      bit mvalid, mready, v, r, acc;
      int exp_d;
      pair_t p;
      @(negedge clk);
      mvalid = (m_full() > 0);
      mready = (m_full() < 2);
      exp_d  = mvalid ? exp_q[0] : 0;
      chk("wr_ready", bus.o_wr_ready, mready);
      chk("valid",    bus.o_valid,    mvalid);
      chk("overflow", bus.o_overflow, movf);
      chk("index",    bus.o_index,    m_idx());
      chk("data",     bus.o_data,     exp_d);
      chk("last",     bus.o_last,     mvalid && (m_idx() == N - 1));

      if (ovf_mode) begin
         v = 1'b1;
         p.aa = AS'($urandom_range(0, N - 1));
         p.ab = AS'($urandom_range(0, N - 1));
         p.da = 8'hAA;
         p.db = 8'hAA;
      end else if (pend.size() > 0 && $urandom_range(0, 99) < vprob) begin
         v = 1'b1;
         p = pend[0];
      end else begin
         v = 1'b0;
         p.aa = '0; p.ab = '0; p.da = '0; p.db = '0;
      end
      if (mvalid && rdy_force.size() > 0) r = rdy_force.pop_front() != 0;
      else r = ($urandom_range(0, 99) < rprob);

      bus.i_wr_valid   = v;
      bus.i_pipeaddr_A = p.aa;
      bus.i_pipeaddr_B = p.ab;
      bus.i_pipedata_A = p.da;
      bus.i_pipedata_B = p.db;
      bus.i_ready      = r;

      acc = v && mready;
      if (v && !mready) movf = 1'b1;
      if (mvalid && r) begin
         cap_q.push_back(int'(bus.o_data));
         void'(exp_q.pop_front());
      end
      if (acc) begin
         mb[mwb][rev(int'(p.aa))] = int'(p.da);
         mb[mwb][rev(int'(p.ab))] = int'(p.db);
         if (!ovf_mode) void'(pend.pop_front());
         mwcnt++;
         if (mwcnt == N / 2) begin
            for (int i = 0; i < N; i++) exp_q.push_back(mb[mwb][i]);
            mwb   = 1 - mwb;
            mwcnt = 0;
         end
      end
   endtask

   task automatic run_idle(input string tag, input int budget);
      bit done = 0;
      for (int c = 0; c < budget && !done; c++) begin
         cycle();
         done = (pend.size() == 0 && exp_q.size() == 0 && mwcnt == 0);
      end
      chk(tag, done, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_wr_valid = 1'b0;
      bus.i_ready    = 1'b0;
      exp_q.delete();
      pend.delete();
      rdy_force.delete();
      mwb = 0; mwcnt = 0; movf = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int seq[N];
      int aa_cnt;
      bit hit;
      bus.i_wr_valid = 1'b0; bus.i_ready = 1'b0;
      bus.i_pipeaddr_A = '0; bus.i_pipeaddr_B = '0;
      bus.i_pipedata_A = '0; bus.i_pipedata_B = '0;
      for (int i = 0; i < N; i++) begin mb[0][i] = 0; mb[1][i] = 0; end
      do_reset();

      // Idle after reset.
      for (int i = 0; i < 10; i++) cycle();

      // Directed single frame: pipeline addresses given directly, data = 10+addr.
      for (int k = 0; k < 4; k++) begin
         pair_t p;
         p.aa = AS'(k == 0 ? 0 : k == 1 ? 2 : k == 2 ? 1 : 3);
         p.ab = p.aa + 3'd4;
         p.da = 8'(10 + int'(p.aa));
         p.db = 8'(10 + int'(p.ab));
         pend.push_back(p);
      end
      cap_q.delete();
      run_idle("single_drain", 100);
      seq = '{10, 14, 12, 16, 11, 15, 13, 17};
      chk("single_count", cap_q.size(), N);
      for (int i = 0; i < N && i < cap_q.size(); i++) chk("single_seq", cap_q[i], seq[i]);

      // Backpressure: three frames with the sink stalled, then release.
      rprob = 0;
      for (int f = 0; f < 3; f++) gen_frame(0);
      for (int i = 0; i < 16; i++) cycle();
      chk("bp_held_pairs", pend.size(), N / 2);
      rprob = 100;
      run_idle("bp_drain", 200);

      // Overflow: fill both banks, hammer with 0xAA, then drain.
      rprob = 0;
      gen_frame(0); gen_frame(0);
      for (int i = 0; i < 40 && pend.size() > 0; i++) cycle();
      ovf_mode = 1;
      for (int i = 0; i < 4; i++) cycle();
      ovf_mode = 0;
      rprob = 100;
      cap_q.delete();
      run_idle("ovf_drain", 200);
      aa_cnt = 0;
      foreach (cap_q[i]) if (cap_q[i] == 'hAA) aa_cnt++;
      chk("ovf_no_aa", aa_cnt, 0);
      chk("ovf_frames", cap_q.size(), 2 * N);

      // Scripted stall pattern during a drain.
      gen_frame(0);
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         cycle();
         hit = (m_full() > 0);
      end
      chk("stall_start", hit, 1);
      rdy_force = '{1, 0, 0, 1, 0, 0, 1};
      run_idle("stall_drain", 100);

      // Random traffic, some frames with lane collisions (stale slot from the bank).
      vprob = 70; rprob = 60;
      for (int f = 0; f < 20; f++) gen_frame($urandom_range(0, 3) == 0);
      run_idle("rand_drain", 2000);

      // Reset while draining at index 3.
      vprob = 100; rprob = 100;
      gen_frame(0); gen_frame(0);
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         cycle();
         hit = (m_full() > 0 && m_idx() == 3);
      end
      chk("reset_point", hit, 1);
      do_reset();
      for (int i = 0; i < 2; i++) cycle();
      gen_frame(0);
      run_idle("post_reset_drain", 100);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
